// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver: condition codes, FSM encoding and PC width.
package branch_resolver_pkg;

  localparam int PC_W = 16;

  localparam logic [2:0] COND_BEQ    = 3'd0;
  localparam logic [2:0] COND_BNE    = 3'd1;
  localparam logic [2:0] COND_BGT    = 3'd2;
  localparam logic [2:0] COND_BLE    = 3'd3;
  localparam logic [2:0] COND_BLT    = 3'd4;
  localparam logic [2:0] COND_BGE    = 3'd5;
  localparam logic [2:0] COND_ALWAYS = 3'd6;
  localparam logic [2:0] COND_RSVD   = 3'd7;

  localparam logic [1:0] ST_IDLE_ENC     = 2'd0;
  localparam logic [1:0] ST_EVAL_ENC     = 2'd1;
  localparam logic [1:0] ST_REDIRECT_ENC = 2'd2;
  localparam logic [1:0] ST_FLUSH_ENC    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = ST_IDLE_ENC,
    ST_EVAL     = ST_EVAL_ENC,
    ST_REDIRECT = ST_REDIRECT_ENC,
    ST_FLUSH    = ST_FLUSH_ENC
  } state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition: (cond, zero, positive) -> take.
// Zero latency; no handshake.
module branch_cond_eval
  import branch_resolver_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       z,
  input  logic       p,
  output logic       take
);

  always_comb begin
    take = 1'b0;
    case (cond)
      COND_BEQ:    take = z;
      COND_BNE:    take = !z;
      COND_BGT:    take = p;
      COND_BLE:    take = !p;
      COND_BLT:    take = !z && !p;
      COND_BGE:    take = z || p;
      COND_ALWAYS: take = 1'b1;
      COND_RSVD:   take = 1'b0;
      default:     take = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Resolves conditional branches against registered ALU flags and redirects fetch.
// Accept -> result in 2 cycles; redirect held until redir_ready, then FLUSH_CYCLES of flush.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flag_we,
  input  logic [15:0]      zero_in,
  input  logic [15:0]      pos_in,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_cond,
  input  logic [PC_W-1:0]  br_pc,
  input  logic [PC_W-1:0]  br_offset,
  output logic             redir_valid,
  input  logic             redir_ready,
  output logic [PC_W-1:0]  redir_pc,
  output logic             flush,
  output logic             resolved,
  output logic             taken,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  localparam int FW         = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int FLUSH_LOAD = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;

  state_t            state_q, state_d;
  logic              z_q, z_d, p_q, p_d;
  logic [2:0]        cond_q, cond_d;
  logic [PC_W-1:0]   pc_q, pc_d, off_q, off_d;
  logic              redir_valid_q, redir_valid_d;
  logic [PC_W-1:0]   redir_pc_q, redir_pc_d;
  logic              flush_q, flush_d;
  logic [FW-1:0]     flush_cnt_q, flush_cnt_d;
  logic              resolved_q, resolved_d;
  logic              taken_q, taken_d;
  logic [CNT_W-1:0]  br_count_q, br_count_d;
  logic [CNT_W-1:0]  taken_count_q, taken_count_d;
  logic              take;

  branch_cond_eval u_cond (
    .cond (cond_q),
    .z    (z_q),
    .p    (p_q),
    .take (take)
  );

  always_comb begin
    state_d       = state_q;
    z_d           = z_q;
    p_d           = p_q;
    cond_d        = cond_q;
    pc_d          = pc_q;
    off_d         = off_q;
    redir_valid_d = redir_valid_q;
    redir_pc_d    = redir_pc_q;
    flush_d       = flush_q;
    flush_cnt_d   = flush_cnt_q;
    resolved_d    = 1'b0;
    taken_d       = taken_q;
    br_count_d    = br_count_q;
    taken_count_d = taken_count_q;

    // Flags track the ALU in every state; an in-flight redirect already holds its target.
    if (flag_we) begin
      z_d = |zero_in;
      p_d = |pos_in;
    end

    case (state_q)
      ST_IDLE: begin
        if (br_valid) begin
          cond_d  = br_cond;
          pc_d    = br_pc;
          off_d   = br_offset;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        resolved_d = 1'b1;
        taken_d    = take;
        if (br_count_q != '1) br_count_d = br_count_q + CNT_W'(1);
        if (take) begin
          if (taken_count_q != '1) taken_count_d = taken_count_q + CNT_W'(1);
          redir_valid_d = 1'b1;
          redir_pc_d    = pc_q + off_q;
          state_d       = ST_REDIRECT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REDIRECT: begin
        if (redir_ready) begin
          redir_valid_d = 1'b0;
          if (FLUSH_CYCLES > 0) begin
            flush_d     = 1'b1;
            flush_cnt_d = FW'(FLUSH_LOAD);
            state_d     = ST_FLUSH;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == '0) begin
          flush_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - FW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      z_q           <= 1'b0;
      p_q           <= 1'b0;
      cond_q        <= '0;
      pc_q          <= '0;
      off_q         <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      flush_q       <= 1'b0;
      flush_cnt_q   <= '0;
      resolved_q    <= 1'b0;
      taken_q       <= 1'b0;
      br_count_q    <= '0;
      taken_count_q <= '0;
    end else begin
      state_q       <= state_d;
      z_q           <= z_d;
      p_q           <= p_d;
      cond_q        <= cond_d;
      pc_q          <= pc_d;
      off_q         <= off_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      flush_q       <= flush_d;
      flush_cnt_q   <= flush_cnt_d;
      resolved_q    <= resolved_d;
      taken_q       <= taken_d;
      br_count_q    <= br_count_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign br_ready    = (state_q == ST_IDLE);
  assign redir_valid = redir_valid_q;
  assign redir_pc    = redir_pc_q;
  assign flush       = flush_q;
  assign resolved    = resolved_q;
  assign taken       = taken_q;
  assign br_count    = br_count_q;
  assign taken_count = taken_count_q;

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Consumes the 16-bit zero/pos flag words produced by the processor's ALU and resolves conditional branches against them.
- Holds a flag register, evaluates the branch condition and computes the target PC.
- Issues a redirect to fetch over a valid/ready handshake, then drives a pipeline flush window.
- Sits between the ALU flag outputs and the fetch/PC logic.

Parameters:
FLUSH_CYCLES, 2, number of cycles flush is asserted after an accepted redirect (0 = no flush window)
CNT_W, 16, width of the saturating branch/taken statistic counters

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
flag_we  input  1  capture zero_in/pos_in into the flag register this edge
zero_in  input  16  ALU zero flag word (16'h0001 = result zero, 16'h0000 otherwise)
pos_in  input  16  ALU positive flag word (16'h0001 = result positive nonzero)
br_valid  input  1  branch request valid
br_ready  output  1  resolver can accept a branch (high only in IDLE)
br_cond  input  3  condition code
br_pc  input  16  PC of branch instruction
br_offset  input  16  signed byte offset added to br_pc
redir_valid  output  1  redirect request to fetch
redir_ready  input  1  fetch accepts redirect
redir_pc  output  16  redirect target
flush  output  1  kill younger instructions
resolved  output  1  one-cycle pulse when a branch finishes (taken or not)
taken  output  1  outcome of last resolved branch, held until next resolve
br_count  output  CNT_W  branches resolved, saturating
taken_count  output  CNT_W  taken branches, saturating

Behaviour:
- Flag register: z_q <= |zero_in, p_q <= |pos_in on flag_we, in any state.
- Reset values:
  - z_q=0, p_q=0.
  - State IDLE; br_ready=1 after reset release.
  - redir_valid=0, redir_pc=0, flush=0, resolved=0, taken=0, both counters=0.
- Conditions, evaluated on z_q/p_q:
  - 0 BEQ: z
  - 1 BNE: !z
  - 2 BGT: p
  - 3 BLE: !p
  - 4 BLT: !z & !p
  - 5 BGE: z | p
  - 6 ALWAYS: 1
  - 7 reserved, never taken
- FSM states: IDLE, EVAL, REDIRECT, FLUSH.
- IDLE:
  - br_ready=1.
  - On br_valid, latch cond/pc/offset and go to EVAL.
- EVAL (exactly 1 cycle):
  - Compute target = br_pc + br_offset, modulo 2^16 (wraps, no overflow flag).
  - Flags used are z_q/p_q as of this cycle. A flag_we coincident with acceptance is therefore seen.
  - Not taken: resolved=1, taken=0, br_count++, return to IDLE.
  - Taken: resolved=1, taken=1, both counters ++, drive redir_pc=target, redir_valid=1, go to REDIRECT.
- REDIRECT:
  - redir_valid and redir_pc are held stable until redir_ready.
  - On the handshake, the next cycle is FLUSH if FLUSH_CYCLES>0, else IDLE.
  - redir_valid drops the cycle after the handshake.
- FLUSH:
  - flush=1 for exactly FLUSH_CYCLES consecutive cycles, using a down-counter loaded at the handshake.
  - Then go to IDLE.
- br_ready is low in EVAL/REDIRECT/FLUSH. br_valid in those states is ignored, not queued.
- Latency:
  - Not-taken: accept to IDLE in 2 cycles.
  - Taken with redir_ready held high: accept to redir_valid in 2 cycles; flush starts 1 cycle after the handshake.
- Counters stop at all-ones and do not wrap.
- Reset asserted mid-operation:
  - Immediately returns to IDLE.
  - Drops redir_valid/flush.
  - Clears flags and counters.
- flag_we during REDIRECT/FLUSH updates the flags only; it does not affect an in-flight redirect.

Decomposition:
- Shared package holds:
  - condition code constants (COND_BEQ..COND_ALWAYS, COND_RSVD)
  - state encoding localparams
  - PC width constant (16)
- One natural sub-module: branch_cond_eval, a combinational (cond, z, p) -> take function, reusable by the decoder.

Test Plan:
- Flags: reset, then flag_we with zero_in=16'h0001, pos_in=0; BEQ with pc=16'h0010, offset=16'h0008, redir_ready=1 -> redir_valid 2 cycles after accept, redir_pc=16'h0018, flush high 2 cycles, taken=1, taken_count=1.
- Not taken: pos_in=16'h0001 flags; BLT -> resolved pulse, taken=0, no redir_valid/flush, br_count increments, br_ready back high 2 cycles after accept.
- Backpressure and wrap:
  - Stimulus: BNE with pc=16'hFFF0, offset=16'h0020, redir_ready low 5 cycles.
  - Response: redir_valid held with redir_pc=16'h0010 stable all 5 cycles, br_valid ignored meanwhile, flush starts after the handshake.
- Coincident flag write: flag_we (zero_in=1) in the same cycle a BEQ is accepted while old z_q=0 -> branch taken.
- Mid-operation reset and condition sweep:
  - Reset: pull reset low during FLUSH -> flush=0, redir_valid=0, counters 0, br_ready=1 after release.
  - Sweep: all 8 cond codes vs flag states (z,p)=(1,0),(0,1),(0,0) -> taken matches the condition list; cond 7 is never taken.
